// File: rtl/load_store_unit.sv
// Data-memory load/store initiator: one request at a time, word-addressed memory,
// sub-word stores by read-modify-write, extended load data and fault reporting.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        data_read_flag,
    output logic        data_write_flag,
    output logic [31:0] data_addr,
    output logic [31:0] val,
    input  logic [31:0] read_out
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        fault_q, fault_d;
    logic        req_fault_s;
    logic [31:0] word_addr_s;

    function automatic logic req_faults(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (addr >= MEM_BYTES) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Little-endian lane replacement for sub-word stores; word size passes new data through.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'b00:   merged[7:0]   = wdata[7:0];
                    2'b01:   merged[15:8]  = wdata[7:0];
                    2'b10:   merged[23:16] = wdata[7:0];
                    2'b11:   merged[31:24] = wdata[7:0];
                    default: merged        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic is_unsigned, input logic [1:0] lane);
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        logic [31:0] result;
        case (lane)
            2'b00:   lane_byte = word[7:0];
            2'b01:   lane_byte = word[15:8];
            2'b10:   lane_byte = word[23:16];
            2'b11:   lane_byte = word[31:24];
            default: lane_byte = 8'h00;
        endcase
        if (lane[1]) begin
            lane_half = word[31:16];
        end else begin
            lane_half = word[15:0];
        end
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'h000000, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: result = is_unsigned ? {16'h0000, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: result = word;
        endcase
        return result;
    endfunction

    assign req_fault_s = req_faults(req_size, req_addr);
    assign word_addr_s = {addr_q[31:2], 2'b00};

    // Next-state and request capture.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        fault_d    = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    fault_d    = req_fault_s;
                    if (req_fault_s) begin
                        state_d = ST_RESP;
                    end else if (!req_write) begin
                        state_d = ST_READ;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                word_d = read_out;
                if (write_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and captured registers only, never from live req_* inputs.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'h0000_0000;
        resp_fault      = 1'b0;
        data_read_flag  = 1'b0;
        data_write_flag = 1'b0;
        data_addr       = 32'h0000_0000;
        val             = 32'h0000_0000;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_READ: begin
                data_read_flag = 1'b1;
                data_addr      = word_addr_s;
            end
            ST_WRITE: begin
                data_write_flag = 1'b1;
                data_addr       = word_addr_s;
                val             = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                if (!fault_q && !write_q) begin
                    resp_rdata = load_extract(word_q, size_q, unsigned_q, addr_q[1:0]);
                end else begin
                    resp_rdata = 32'h0000_0000;
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

    // State and captured-request registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            word_q     <= 32'h0000_0000;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, transaction-level reference model with a
// per-cycle compare process, and directed requests pinned by literal expectations.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 32;
    localparam logic [31:0] MEM_BYTES = 32'd128;
    localparam int K_FAULT = 0, K_LOAD = 1, K_WST = 2, K_SST = 3;
    localparam int PH_IDLE = 0, PH_READ = 1, PH_WRITE = 2, PH_RESP = 3;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        data_read_flag, data_write_flag;
    logic [31:0] data_addr, val, read_out;

    logic [31:0] mem     [0:31];
    logic [31:0] ref_mem [0:31];
    logic        init_done;
    int          n_checks, n_fail;

    bit          busy_m;
    int          kind_m, k_m;
    logic [31:0] exp_addr_m, exp_val_m, exp_rdata_m;
    logic        exp_fault_m;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .data_read_flag(data_read_flag),
        .data_write_flag(data_write_flag), .data_addr(data_addr), .val(val),
        .read_out(read_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            8:       return 32'h1122_3344;
            12:      return 32'h80F1_7F01;
            16:      return 32'hCAFE_F00D;
            default: return {8'hA5, i[7:0], 16'h5A5A};
        endcase
    endfunction

    function automatic logic flt_model(input logic [1:0] sz, input logic [31:0] a);
        if (a >= MEM_BYTES) return 1'b1;
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 32'd2) != 32'd0;
            2'd2:    return (a % 32'd4) != 32'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int bits_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : ((sz == 2'd1) ? 16 : 32);
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [1:0] sz,
                                              input logic uns, input logic [31:0] a);
        int bits, sh;
        logic [31:0] mask, v;
        bits = bits_of(sz);
        if (bits == 32) return w;
        sh   = 8 * int'(a[1:0]);
        mask = (32'd1 << bits) - 32'd1;
        v    = (w >> sh) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [31:0] a);
        int bits, sh;
        logic [31:0] mask;
        bits = bits_of(sz);
        if (bits == 32) return wd;
        sh   = 8 * int'(a[1:0]);
        mask = ((32'd1 << bits) - 32'd1) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic int kind_of(input logic f, input logic w, input logic [1:0] sz);
        if (f) return K_FAULT;
        if (!w) return K_LOAD;
        return (sz == 2'd2) ? K_WST : K_SST;
    endfunction

    function automatic int lat_of(input int kind);
        return (kind == K_FAULT) ? 1 : ((kind == K_SST) ? 3 : 2);
    endfunction

    // Timeline of a transaction: which memory phase occupies cycle k after the accept edge.
    function automatic int phase_of(input int kind, input int k);
        if (k == lat_of(kind)) return PH_RESP;
        if (kind == K_WST) return PH_WRITE;
        if (kind == K_SST && k == 2) return PH_WRITE;
        return PH_READ;
    endfunction

    assign read_out = data_read_flag ? mem[data_addr[6:2]] : 32'h0000_0000;

    // Data memory attached to the unit.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (data_write_flag && data_addr < MEM_BYTES) begin
            mem[data_addr[6:2]] <= val;
        end
    end

    // Reference model: tracks accepts, expected timeline and memory contents.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_m <= 1'b0;
            k_m    <= 0;
            if (!init_done) begin
                for (int i = 0; i < 32; i++) ref_mem[i] <= init_word(i);
            end
        end else if (!busy_m) begin
            if (req_valid) begin
                busy_m      <= 1'b1;
                k_m         <= 1;
                kind_m      <= kind_of(flt_model(req_size, req_addr), req_write, req_size);
                exp_fault_m <= flt_model(req_size, req_addr);
                exp_addr_m  <= {req_addr[31:2], 2'b00};
                exp_val_m   <= merge_model(ref_mem[req_addr[6:2]], req_wdata, req_size, req_addr);
                exp_rdata_m <= (flt_model(req_size, req_addr) || req_write) ? 32'h0 :
                               ext_model(ref_mem[req_addr[6:2]], req_size, req_unsigned, req_addr);
            end
        end else begin
            if (phase_of(kind_m, k_m) == PH_WRITE) ref_mem[exp_addr_m[6:2]] <= exp_val_m;
            if (k_m == lat_of(kind_m)) busy_m <= 1'b0;
            k_m <= k_m + 1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        int ph;
        if (init_done) begin
            if (!rst) begin
                check_bit("rst_ready", req_ready, 1'b1);
                check_bit("rst_rd_flag", data_read_flag, 1'b0);
                check_bit("rst_wr_flag", data_write_flag, 1'b0);
                check_bit("rst_resp_valid", resp_valid, 1'b0);
                check_word("rst_data_addr", data_addr, 32'h0);
                check_word("rst_val", val, 32'h0);
                check_word("rst_rdata", resp_rdata, 32'h0);
            end else begin
                ph = busy_m ? phase_of(kind_m, k_m) : PH_IDLE;
                check_bit("req_ready", req_ready, ph == PH_IDLE);
                check_bit("rd_flag", data_read_flag, ph == PH_READ);
                check_bit("wr_flag", data_write_flag, ph == PH_WRITE);
                check_bit("resp_valid", resp_valid, ph == PH_RESP);
                check_bit("flags_exclusive", data_read_flag & data_write_flag, 1'b0);
                if (ph == PH_READ || ph == PH_WRITE) check_word("data_addr", data_addr, exp_addr_m);
                if (ph == PH_WRITE) check_word("val", val, exp_val_m);
                if (ph == PH_RESP) begin
                    check_word("resp_rdata", resp_rdata, exp_rdata_m);
                    check_bit("resp_fault", resp_fault, exp_fault_m);
                end
            end
        end
    end

    task automatic wait_resp(output logic [31:0] rd, output logic flt, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!resp_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_bit("resp_timeout", resp_valid, 1'b1);
        rd  = resp_rdata;
        flt = resp_fault;
        lat = t + 1;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat);
        int t;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_bit("accept_timeout", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w; req_size = 2'($urandom_range(0, 3)); req_unsigned = ~uns;
        req_addr = $urandom; req_wdata = $urandom;
        wait_resp(rd, flt, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        f;
        int          lat;
        n_checks = 0; n_fail = 0; init_done = 1'b0;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Word store then load.
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, r, f, lat);
        check_bit("t1_store_fault", f, 1'b0);
        check_word("t1_store_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, f, lat);
        check_word("t1_load", r, 32'hDEAD_BEEF);
        check_word("t1_load_lat", 32'(lat), 32'd2);

        // Sub-word read-modify-write.
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, r, f, lat);
        check_word("t2_byte_lat", 32'(lat), 32'd3);
        check_word("t2_mem_byte", mem[8], 32'h11AA_3344);
        do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_5566, r, f, lat);
        check_word("t2_mem_half", mem[8], 32'h11AA_5566);

        // Sign and zero extension.
        do_req(1'b0, 2'd0, 1'b0, 32'h31, 32'h0, r, f, lat);
        check_word("t3_sbyte_31", r, 32'h0000_007F);
        do_req(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, r, f, lat);
        check_word("t3_sbyte_33", r, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, r, f, lat);
        check_word("t3_ubyte_33", r, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, r, f, lat);
        check_word("t3_shalf_32", r, 32'hFFFF_80F1);
        do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, r, f, lat);
        check_word("t3_uhalf_30", r, 32'h0000_7F01);

        // Faults and the top-of-memory boundary.
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, r, f, lat);
        check_bit("t4_word_misaligned", f, 1'b1);
        check_word("t4_fault_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, r, f, lat);
        check_bit("t4_half_misaligned", f, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, r, f, lat);
        check_bit("t4_illegal_size", f, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678, r, f, lat);
        check_bit("t4_out_of_range", f, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, r, f, lat);
        check_word("t4_mem0_unchanged", r, 32'hA500_5A5A);
        do_req(1'b1, 2'd0, 1'b0, 32'h7F, 32'h0000_00EE, r, f, lat);
        check_bit("t4_last_byte_ok", f, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, r, f, lat);
        check_word("t4_last_word", r, 32'hEE1F_5A5A);

        // Reset in the read phase of a byte store.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000_0077; req_valid = 1'b1;
        check_bit("t5_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        check_bit("t5_read_before_rst", data_read_flag, 1'b1);
        rst = 1'b0;
        #1;
        check_bit("t5_rd_dropped", data_read_flag, 1'b0);
        check_bit("t5_wr_dropped", data_write_flag, 1'b0);
        check_bit("t5_ready_in_rst", req_ready, 1'b1);
        check_bit("t5_no_resp", resp_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, f, lat);
        check_word("t5_load_after_rst", r, 32'hCAFE_F00D);

        // Back-to-back requests with req_valid held high.
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        check_bit("t6_ready_a", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_write = 1'b1; req_size = 2'd1; req_addr = 32'h12; req_wdata = 32'h0000_1234;
        wait_resp(r, f, lat);
        check_word("t6_a_rdata", r, 32'hDEAD_BEEF);
        check_word("t6_a_lat", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        check_bit("t6_not_taken_in_resp", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_bit("t6_b_taken", req_ready, 1'b0);
        wait_resp(r, f, lat);
        check_word("t6_b_lat", 32'(lat), 32'd3);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, f, lat);
        check_word("t6_result", r, 32'h1234_BEEF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
